// File: rtl/ro_puf_pkg.sv
// Shared state encoding, phase lengths and timer sizing for the RO PUF sequencer.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } ro_puf_state_t;

  localparam int CLEAR_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam int NUM_VOTES     = 3;

  // Timer must hold WINDOW_CYCLES-1 as well as the fixed CLEAR/SETTLE reloads.
  function automatic int timer_width(input int window_cycles);
    int w;
    w = $clog2(window_cycles + 1);
    if (w < $clog2(CLEAR_CYCLES))  w = $clog2(CLEAR_CYCLES);
    if (w < $clog2(SETTLE_CYCLES)) w = $clog2(SETTLE_CYCLES);
    if (w < 1)                     w = 1;
    return w;
  endfunction

endpackage

// File: rtl/ro_puf_ctrl_window_timer.sv
// Loadable down-counter timing the CLEAR, MEASURE and SETTLE phases.
// Loading N-1 yields expire on the N-th cycle after the load.
module window_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement sequencer: clear, gate, settle, capture, compare.
// Optional build macro RO_PUF_CTRL_MAJORITY_EN runs three passes and votes the response.
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int  NUM_BITS      = 32,
  parameter int  NUM_RO        = 16,
  parameter int  WINDOW_CYCLES = 1024,
  localparam int SEL_W         = $clog2(NUM_RO)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel_a,
  input  logic [SEL_W-1:0]    sel_b,
  output logic                busy,
  output logic                done,
  output logic                response,
  output logic                err,
  output logic                tie,
  output logic [SEL_W-1:0]    ro_sel_a,
  output logic [SEL_W-1:0]    ro_sel_b,
  output logic                ro_enable,
  output logic                cnt_clear,
  output logic                cnt_enable,
  input  logic [NUM_BITS-1:0] count_a,
  input  logic [NUM_BITS-1:0] count_b,
  output logic [NUM_BITS-1:0] count_a_q,
  output logic [NUM_BITS-1:0] count_b_q
);

  localparam int                 TIMER_W      = timer_width(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD   = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MEASURE_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES - 1);

  ro_puf_state_t state_reg, state_next;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expire;

  logic accept, illegal, last_pass;
  logic a_gt_b, a_eq_b, resp_next, tie_next, done_next;

  logic                busy_reg, done_reg, response_reg, err_reg, tie_reg;
  logic                ro_enable_reg, cnt_clear_reg, cnt_enable_reg, err_pending_reg;
  logic [SEL_W-1:0]    ro_sel_a_reg, ro_sel_b_reg;
  logic [NUM_BITS-1:0] count_a_q_reg, count_b_q_reg;

  window_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (timer_load),
    .load_value(timer_value),
    .expire    (timer_expire)
  );

  assign illegal = (sel_a == sel_b) || (32'(sel_a) >= NUM_RO) || (32'(sel_b) >= NUM_RO);
  assign accept  = (state_reg == ST_IDLE) && start;

  // Compared against the live counter outputs during CAPTURE; they are static after SETTLE.
  assign a_gt_b = (count_a > count_b);
  assign a_eq_b = (count_a == count_b);

`ifdef RO_PUF_CTRL_MAJORITY_EN
  logic [1:0] pass_reg, vote_reg;
  logic       tie_any_reg;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      pass_reg    <= '0;
      vote_reg    <= '0;
      tie_any_reg <= 1'b0;
    end else if (accept) begin
      pass_reg    <= '0;
      vote_reg    <= '0;
      tie_any_reg <= 1'b0;
    end else if (state_reg == ST_CAPTURE) begin
      pass_reg    <= pass_reg + 2'd1;
      vote_reg    <= vote_reg + {1'b0, a_gt_b};
      tie_any_reg <= tie_any_reg | a_eq_b;
    end
  end

  assign last_pass = (pass_reg == 2'(NUM_VOTES - 1));
  assign resp_next = ((vote_reg + {1'b0, a_gt_b}) >= 2'((NUM_VOTES + 1) / 2));
  assign tie_next  = tie_any_reg | a_eq_b;
`else
  assign last_pass = 1'b1;
  assign resp_next = a_gt_b;
  assign tie_next  = a_eq_b;
`endif

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (illegal) begin
            state_next = ST_DONE;
          end else begin
            state_next  = ST_CLEAR;
            timer_load  = 1'b1;
            timer_value = CLEAR_LOAD;
          end
        end
      end
      ST_CLEAR: begin
        if (timer_expire) begin
          state_next  = ST_MEASURE;
          timer_load  = 1'b1;
          timer_value = MEASURE_LOAD;
        end
      end
      ST_MEASURE: begin
        if (timer_expire) begin
          state_next  = ST_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_expire) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (last_pass) begin
          state_next = ST_DONE;
        end else begin
          state_next  = ST_CLEAR;
          timer_load  = 1'b1;
          timer_value = CLEAR_LOAD;
        end
      end
      // An illegal challenge enters DONE straight from IDLE and dwells one extra
      // cycle, so the pulse lands one cycle after busy rises.
      ST_DONE: begin
        if (done_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign done_next = (state_next == ST_DONE) && (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      response_reg    <= 1'b0;
      err_reg         <= 1'b0;
      tie_reg         <= 1'b0;
      ro_enable_reg   <= 1'b0;
      cnt_clear_reg   <= 1'b1;
      cnt_enable_reg  <= 1'b0;
      err_pending_reg <= 1'b0;
      ro_sel_a_reg    <= '0;
      ro_sel_b_reg    <= '0;
      count_a_q_reg   <= '0;
      count_b_q_reg   <= '0;
    end else begin
      busy_reg       <= (state_next != ST_IDLE);
      done_reg       <= done_next;
      cnt_clear_reg  <= (state_next == ST_IDLE) || (state_next == ST_CLEAR);
      ro_enable_reg  <= (state_next == ST_CLEAR) || (state_next == ST_MEASURE);
      cnt_enable_reg <= (state_next == ST_MEASURE);
      if (accept) begin
        ro_sel_a_reg    <= sel_a;
        ro_sel_b_reg    <= sel_b;
        err_pending_reg <= illegal;
      end
      if (state_reg == ST_CAPTURE) begin
        count_a_q_reg <= count_a;
        count_b_q_reg <= count_b;
      end
      if (done_next) begin
        err_reg      <= err_pending_reg;
        response_reg <= err_pending_reg ? 1'b0 : resp_next;
        tie_reg      <= err_pending_reg ? 1'b0 : tie_next;
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign response   = response_reg;
  assign err        = err_reg;
  assign tie        = tie_reg;
  assign ro_sel_a   = ro_sel_a_reg;
  assign ro_sel_b   = ro_sel_b_reg;
  assign ro_enable  = ro_enable_reg;
  assign cnt_clear  = cnt_clear_reg;
  assign cnt_enable = cnt_enable_reg;
  assign count_a_q  = count_a_q_reg;
  assign count_b_q  = count_b_q_reg;

endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Sequencer for the ring-oscillator PUF measurement datapath. On a challenge it selects two ring oscillators, zeroes and gates the pair of edge counters for a fixed clock window, waits for the asynchronous counts to settle, captures them and emits one response bit (A faster than B). It sits between the challenge/response host logic and the RO bank plus its two `counter` instances.

## Interface
Parameters:
- `NUM_BITS`, 32: counter width; matches the counter instances.
- `NUM_RO`, 16: number of ring oscillators; select width `SEL_W = $clog2(NUM_RO)`.
- `WINDOW_CYCLES`, 1024: gate window length in `clk` cycles; legal range 1 to 2^20.

Ports:
- `clk`, in, 1: system clock.
- `arst_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: challenge request; sampled only in IDLE.
- `sel_a` / `sel_b`, in, SEL_W: challenge oscillator indices.
- `busy`, out, 1: high from the cycle after `start` is accepted until the cycle `done` is high.
- `done`, out, 1: one-cycle completion pulse.
- `response`, out, 1: 1 if `count_a > count_b`; held until the next `done`.
- `err`, out, 1: illegal challenge; valid with `done`.
- `tie`, out, 1: `count_a == count_b`; valid with `done`.
- `ro_sel_a` / `ro_sel_b`, out, SEL_W: latched oscillator selects.
- `ro_enable`, out, 1: RO bank oscillate enable.
- `cnt_clear`, out, 1: drives the counters' reset.
- `cnt_enable`, out, 1: drives the counters' enable.
- `count_a` / `count_b`, in, NUM_BITS: counter outputs.
- `count_a_q` / `count_b_q`, out, NUM_BITS: captured counts; held until the next capture.

## Operation
- All outputs are registered.
- Reset values: all outputs 0 except `cnt_clear` = 1. The FSM goes to IDLE.
- FSM states: IDLE, CLEAR, MEASURE, SETTLE, CAPTURE, DONE.
- IDLE:
  - `cnt_clear` = 1, `ro_enable` = 0.
  - `start` = 1 latches `sel_a` and `sel_b`.
  - If `sel_a == sel_b` or either index is ≥ NUM_RO, go to DONE with `err` = 1 and `response` = 0. Otherwise go to CLEAR.
- CLEAR: 4 cycles (`CLEAR_CYCLES`). `cnt_clear` = 1, `ro_enable` = 1 (RO warm-up).
- MEASURE: exactly WINDOW_CYCLES cycles. `cnt_clear` = 0, `cnt_enable` = 1, `ro_enable` = 1.
- SETTLE: 4 cycles (`SETTLE_CYCLES`). `cnt_enable` = 0, `ro_enable` = 0; lets the RO-domain counts go static.
- CAPTURE: 1 cycle. Registers `count_a` and `count_b` into `count_a_q` / `count_b_q`.
- DONE: 1 cycle.
  - `done` = 1; `response`, `tie` and `err` update.
  - When equal, `response` = 0 and `tie` = 1.
  - Next state is IDLE.
- Comparison is unsigned and full width. Counter wrap is not detected; size NUM_BITS accordingly.
- `start` while busy is ignored, not queued.
- `start` held high re-triggers on the first IDLE cycle after DONE.
- Reset mid-operation aborts immediately to IDLE. No `done` is issued and the outputs take their reset values.

## Timing
- `start` is sampled in cycle 0 and `busy` rises in cycle 1.
- One pass (CLEAR through CAPTURE) = WINDOW_CYCLES + 9 cycles.
- `done` is high in cycle 1 + P×(WINDOW_CYCLES + 9), where P = number of passes (1 without majority).
  - Default configuration: `done` in cycle 1034.
- Illegal challenge: `done` and `err` in cycle 2.
- Earliest next accept: the cycle after `done`.

## Configuration
- Macro `RO_PUF_CTRL_MAJORITY_EN`.
- Defined:
  - Each challenge runs 3 full passes; each pass re-enters CLEAR.
  - A 2-bit vote counter accumulates the per-pass comparison results.
  - `response` = majority (≥ 2 of 3).
  - `tie` = 1 if any pass tied.
  - `count_*_q` hold the last pass's counts.
- Undefined: single pass, no vote logic.

## Structure
- Package `ro_puf_pkg` holds:
  - the state enum `ro_puf_state_t`;
  - the constants `CLEAR_CYCLES = 4`, `SETTLE_CYCLES = 4` and `NUM_VOTES = 3`.
- Sub-module `window_timer`:
  - loadable down-counter of width `$clog2(WINDOW_CYCLES+1)`;
  - `load` / `expire` interface;
  - reused for the CLEAR, MEASURE and SETTLE durations.

## Test plan
- Reset, then WINDOW_CYCLES = 16, `sel_a` = 2, `sel_b` = 5, model `count_a` = 900 and `count_b` = 850 at capture:
  - `done` in cycle 26, `response` = 1, `tie` = 0, `err` = 0;
  - `cnt_enable` high for exactly 16 cycles.
- `sel_a` = `sel_b` = 3 → `done` in cycle 2 with `err` = 1, `response` = 0; `ro_enable` never rises.
- Counts 700 and 700 → `response` = 0, `tie` = 1.
- Pulse `start` during MEASURE → ignored, and exactly one `done` is seen. Assert `arst_n` = 0 for one cycle mid-MEASURE:
  - the next cycle has `busy` = 0, `cnt_clear` = 1, `cnt_enable` = 0;
  - no `done` is issued.
- With `RO_PUF_CTRL_MAJORITY_EN` and WINDOW_CYCLES = 16, per-pass results A>B, A<B, A>B:
  - `done` in cycle 76, `response` = 1;
  - `cnt_clear` pulses 3 times.
